booth_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one Booth multiplier datapath and its controller among NREQ requesters. It latches the winning requester's operands and pulses the multiplier start. It then waits for done, with a watchdog, and returns the 2n-bit product plus the requester id through a one-cycle acknowledge. The block sits between the requesting units and the multiplier's start/done/operand ports; the multiplier itself is unchanged.

---
 rtl/booth_mul_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_arbiter
// Purpose  : Round-robin sharing of one Booth multiplier among NREQ requesters,
//            with start/done sequencing, a watchdog and a one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter #(
    parameter int n       = 16,
    parameter int w       = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4 * n + 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*n-1:0]       a_in,
    input  logic [NREQ*n-1:0]       b_in,
    output logic [NREQ-1:0]         ack,
    output logic [2*n-1:0]          result,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_valid,
    output logic                    err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [n-1:0]            mul_a,
    output logic [n-1:0]            mul_b,
    input  logic                    mul_done,
    input  logic [2*n-1:0]          mul_product
);

    localparam int c_ID_W = $clog2(NREQ);
    // A non-positive TIMEOUT falls back to a bound derived from the multiplier's counter width.
    localparam int c_TIMEOUT = (TIMEOUT > 0) ? TIMEOUT : 4 * (1 << w) + 8;
    localparam int c_WD_W    = $clog2(c_TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(c_TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_SAT  = c_WD_W'(c_TIMEOUT);
    localparam logic [NREQ-1:0]   c_ONE     = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_WD_W-1:0]   r_wd;

    logic                w_grant_vld;
    logic [c_ID_W-1:0]   w_grant_id;
    logic [c_ID_W-1:0]   w_cand;
    logic [n-1:0]        w_grant_a;
    logic [n-1:0]        w_grant_b;

    // Offsets are scanned from farthest to nearest so the nearest set bit after r_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = r_ptr;
        w_cand      = r_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = c_ID_W'((int'(r_ptr) + k) % NREQ);
            if (req[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_cand;
            end
        end
        w_grant_a = a_in[n-1:0];
        w_grant_b = b_in[n-1:0];
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == c_ID_W'(i)) begin
                w_grant_a = a_in[i*n +: n];
                w_grant_b = b_in[i*n +: n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_ID_W'(NREQ - 1);
            r_wd      <= '0;
            ack       <= '0;
            result    <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            mul_start <= 1'b0;
            ack       <= '0;
            res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_state   <= S_ISSUE;
                        r_ptr     <= w_grant_id;
                        res_id    <= w_grant_id;
                        mul_a     <= w_grant_a;
                        mul_b     <= w_grant_b;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wd < c_WD_SAT) begin
                        r_wd <= r_wd + 1'b1;
                    end
                    // r_wd == 0 marks the first WAIT cycle, where done may be left over from the last operation.
                    if (mul_done && (r_wd != '0)) begin
                        result    <= mul_product;
                        err       <= 1'b0;
                        ack       <= c_ONE << res_id;
                        res_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (r_wd >= c_WD_LAST) begin
                        result    <= '0;
                        err       <= 1'b1;
                        ack       <= c_ONE << res_id;
                        res_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
